// File: rtl/spi_adc_responder_if.sv
// Sample-source and SPI pin bundle for one emulated ADC receive channel.
`timescale 1ns/1ps
interface spi_adc_responder_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FIFO_DEPTH = 8
);
   localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

   logic [DATA_WIDTH-1:0] sample_in;
   logic                  sample_valid_in;
   logic                  sample_ready_out;
   logic                  chip_clk_in;
   logic                  chip_sel_in;
   logic                  chip_data_out;
   logic                  frame_done_out;
   logic                  frame_abort_out;
   logic                  underflow_out;
   logic [LEVEL_W-1:0]    level_out;

   // Sample source plus SPI controller side.
   modport master (
      output sample_in, sample_valid_in, chip_clk_in, chip_sel_in,
      input  sample_ready_out, chip_data_out, frame_done_out, frame_abort_out,
             underflow_out, level_out
   );

   // Responder side.
   modport slave (
      input  sample_in, sample_valid_in, chip_clk_in, chip_sel_in,
      output sample_ready_out, chip_data_out, frame_done_out, frame_abort_out,
             underflow_out, level_out
   );
endinterface

// File: rtl/spi_adc_responder.sv
// Emulated ADC channel: buffers 16-bit samples and shifts one out MSB-first
// per chip-select frame on cipo.
`timescale 1ns/1ps
module spi_adc_responder #(
   parameter int unsigned          DATA_WIDTH  = 16,
   parameter int unsigned          FIFO_DEPTH  = 8,
   parameter int unsigned          SYNC_STAGES = 2,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '0
) (
   input  logic                clk_in,
   input  logic                rst_in,
   spi_adc_responder_if.slave  bus
);
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned LEVEL_W = PTR_W + 1;
   localparam int unsigned CNT_W   = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   logic sclk_s, cs_s;
   logic sclk_d, cs_d;
   logic cs_fall, cs_rise, sclk_fall;

   // Metastability synchronisers on the controller-driven pins.
   if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sclk_sync;
      logic [SYNC_STAGES-1:0] cs_sync;

      // Idle levels at reset: sclk low, cs deasserted.
      always_ff @(posedge clk_in or posedge rst_in) begin
         if (rst_in) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
         end else begin
            sclk_sync[0] <= bus.chip_clk_in;
            cs_sync[0]   <= bus.chip_sel_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
               sclk_sync[i] <= sclk_sync[i-1];
               cs_sync[i]   <= cs_sync[i-1];
            end
         end
      end

      assign sclk_s = sclk_sync[SYNC_STAGES-1];
      assign cs_s   = cs_sync[SYNC_STAGES-1];
   end else begin : g_nosync
      assign sclk_s = bus.chip_clk_in;
      assign cs_s   = bus.chip_sel_in;
   end

   // History flops for edge detection.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sclk_d <= 1'b0;
         cs_d   <= 1'b1;
      end else begin
         sclk_d <= sclk_s;
         cs_d   <= cs_s;
      end
   end

   assign cs_fall   =  cs_d & ~cs_s;
   assign cs_rise   = ~cs_d &  cs_s;
   assign sclk_fall =  sclk_d & ~sclk_s;

   // Sample buffer.
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [LEVEL_W-1:0]    level_q, level_n;
   logic                  ready_q;
   logic                  enq, deq;
   logic [DATA_WIDTH-1:0] head;

   assign enq     = bus.sample_valid_in & ready_q;
   assign head    = mem[rd_ptr];
   assign level_n = level_q + LEVEL_W'(enq) - LEVEL_W'(deq);

   // Storage array needs no reset; level/pointers define validity.
   always_ff @(posedge clk_in) begin
      if (enq) mem[wr_ptr] <= bus.sample_in;
   end

   // Pointers, occupancy and registered ready.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         ready_q <= 1'b1;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
         level_q <= level_n;
         ready_q <= (level_n < LEVEL_W'(FIFO_DEPTH));
      end
   end

   // Frame FSM and shifter.
   state_t                state_q, state_n;
   logic [DATA_WIDTH-1:0] shift_q, shift_n;
   logic [CNT_W-1:0]      cnt_q, cnt_n;
   logic                  data_q, data_n;
   logic                  done_q, done_n;
   logic                  abort_q, abort_n;
   logic                  under_q, under_n;

   // State and output registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         data_q  <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         under_q <= 1'b0;
      end else begin
         state_q <= state_n;
         shift_q <= shift_n;
         cnt_q   <= cnt_n;
         data_q  <= data_n;
         done_q  <= done_n;
         abort_q <= abort_n;
         under_q <= under_n;
      end
   end

   // Next-state: load on cs fall, shift on sclk fall, cs rise has priority.
   always_comb begin
      state_n = state_q;
      shift_n = shift_q;
      cnt_n   = cnt_q;
      data_n  = data_q;
      done_n  = 1'b0;
      abort_n = 1'b0;
      under_n = under_q;
      deq     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cs_fall) begin
               if (level_q != '0) begin
                  shift_n = head;
                  deq     = 1'b1;
               end else begin
                  shift_n = IDLE_WORD;
                  under_n = 1'b1;
               end
               data_n  = shift_n[DATA_WIDTH-1];
               cnt_n   = CNT_W'(DATA_WIDTH - 1);
               state_n = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (cs_rise) begin
               abort_n = 1'b1;
               data_n  = 1'b0;
               state_n = S_IDLE;
            end else if (sclk_fall) begin
               if (cnt_q != '0) begin
                  shift_n = shift_q << 1;
                  data_n  = shift_q[DATA_WIDTH-2];
                  cnt_n   = cnt_q - CNT_W'(1);
               end else begin
                  data_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (cs_rise) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.sample_ready_out = ready_q;
   assign bus.level_out        = level_q;
   assign bus.chip_data_out    = data_q;
   assign bus.frame_done_out   = done_q;
   assign bus.frame_abort_out  = abort_q;
   assign bus.underflow_out    = under_q;
endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: directed vectors, corner sequences and a
// randomized run checked against a queue-based model of the channel.
`timescale 1ns/1ps
module tb_spi_adc_responder;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned SYNC  = 2;
   localparam logic [15:0] IDLE  = 16'h0000;
   localparam int          HALF  = 5;

   logic clk_in, rst_in;

   spi_adc_responder_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus();

   spi_adc_responder #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .IDLE_WORD(IDLE)
   ) dut (
      .clk_in(clk_in),
      .rst_in(rst_in),
      .bus(bus)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;
   int abort_cnt = 0;

   // Reference model: sample queue plus sticky underflow.
   logic [15:0] mq[$];
   bit          m_under = 0;

   always @(negedge clk_in) begin
      if (bus.frame_done_out === 1'b1)  done_cnt++;
      if (bus.frame_abort_out === 1'b1) abort_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic enqueue(input logic [15:0] w);
      @(posedge clk_in); #1;
      bus.sample_in       = w;
      bus.sample_valid_in = 1'b1;
      chk("ready", 32'(bus.sample_ready_out), 32'(mq.size() < DEPTH));
      @(posedge clk_in); #1;
      bus.sample_valid_in = 1'b0;
      if (mq.size() < DEPTH) mq.push_back(w);
      chk("level_after_enq", 32'(bus.level_out), 32'(mq.size()));
   endtask

   // Drives one frame of nbits sclk cycles; nbits < 16 ends it early.
   task automatic run_frame(input int nbits, input bit enq_fall, input logic [15:0] enq_word,
                            output logic [15:0] rx);
      rx = '0;
      @(posedge clk_in); #1;
      bus.chip_sel_in = 1'b0;
      if (enq_fall) begin
         repeat (SYNC) @(posedge clk_in);
         #1;
         bus.sample_in       = enq_word;
         bus.sample_valid_in = 1'b1;
         @(posedge clk_in); #1;
         bus.sample_valid_in = 1'b0;
      end
      repeat (6) @(posedge clk_in);
      #1;
      for (int i = 0; i < nbits; i++) begin
         bus.chip_clk_in = 1'b1;
         rx = {rx[14:0], bus.chip_data_out};
         repeat (HALF) @(posedge clk_in);
         #1;
         bus.chip_clk_in = 1'b0;
         repeat (HALF) @(posedge clk_in);
         #1;
      end
      repeat (2) @(posedge clk_in);
      #1;
      bus.chip_sel_in = 1'b1;
      repeat (6) @(posedge clk_in);
      #1;
   endtask

   // One frame checked against the model.
   task automatic do_frame(input int nbits, input bit enq_fall, input logic [15:0] enq_word,
                           output logic [15:0] rx);
      logic [15:0] exp;
      int d0, a0;
      if (mq.size() == 0) begin
         exp     = IDLE;
         m_under = 1'b1;
      end else begin
         exp = mq.pop_front();
      end
      d0 = done_cnt;
      a0 = abort_cnt;
      run_frame(nbits, enq_fall, enq_word, rx);
      if (enq_fall && mq.size() < DEPTH) mq.push_back(enq_word);
      if (nbits >= 16) begin
         chk("frame_word", 32'(rx), 32'(exp));
         chk("done_pulses", 32'(done_cnt - d0), 32'd1);
         chk("no_abort", 32'(abort_cnt - a0), 32'd0);
      end else begin
         chk("abort_pulses", 32'(abort_cnt - a0), 32'd1);
         chk("no_done", 32'(done_cnt - d0), 32'd0);
      end
      chk("level_after_frame", 32'(bus.level_out), 32'(mq.size()));
      chk("underflow", 32'(bus.underflow_out), 32'(m_under));
      chk("cipo_idle", 32'(bus.chip_data_out), 32'd0);
   endtask

   typedef struct {
      logic [15:0] sample;
      logic [15:0] exp_bits;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [15:0] rx;
      logic [15:0] words[9];

      vecs[0] = '{16'hA5C3, 16'b1010010111000011};
      vecs[1] = '{16'hFFFF, 16'b1111111111111111};
      vecs[2] = '{16'h0001, 16'b0000000000000001};
      vecs[3] = '{16'h8000, 16'b1000000000000000};
      vecs[4] = '{16'h1234, 16'b0001001000110100};

      bus.sample_in       = '0;
      bus.sample_valid_in = 1'b0;
      bus.chip_clk_in     = 1'b0;
      bus.chip_sel_in     = 1'b1;
      rst_in              = 1'b1;
      repeat (4) @(posedge clk_in);
      #1;
      chk("rst_ready", 32'(bus.sample_ready_out), 32'd1);
      chk("rst_level", 32'(bus.level_out), 32'd0);
      chk("rst_cipo", 32'(bus.chip_data_out), 32'd0);
      chk("rst_underflow", 32'(bus.underflow_out), 32'd0);
      chk("rst_done", 32'(bus.frame_done_out), 32'd0);
      chk("rst_abort", 32'(bus.frame_abort_out), 32'd0);
      rst_in = 1'b0;
      repeat (3) @(posedge clk_in);

      // Directed single-word frames.
      for (int v = 0; v < 5; v++) begin
         enqueue(vecs[v].sample);
         chk("vec_level_one", 32'(bus.level_out), 32'd1);
         do_frame(16, 1'b0, 16'h0, rx);
         chk("vec_bits", 32'(rx), 32'(vecs[v].exp_bits));
      end

      // Overfill: ninth word refused, eight frames in order.
      for (int i = 0; i < 9; i++) begin
         words[i] = 16'h1100 + 16'(i * 16'h0111);
         enqueue(words[i]);
      end
      chk("full_level", 32'(bus.level_out), 32'(DEPTH));
      chk("full_ready", 32'(bus.sample_ready_out), 32'd0);
      for (int i = 0; i < 8; i++) begin
         do_frame(16, 1'b0, 16'h0, rx);
         chk("fill_order", 32'(rx), 32'(words[i]));
      end
      chk("drained_ready", 32'(bus.sample_ready_out), 32'd1);

      // Empty buffer frame: idle word and sticky underflow.
      do_frame(16, 1'b0, 16'h0, rx);
      chk("empty_word", 32'(rx), 32'(IDLE));
      chk("underflow_set", 32'(bus.underflow_out), 32'd1);
      enqueue(16'h3C3C);
      do_frame(16, 1'b0, 16'h0, rx);
      chk("underflow_sticky", 32'(bus.underflow_out), 32'd1);

      // Abort after five sclk cycles discards the loaded word.
      enqueue(16'hFFFF);
      enqueue(16'h1357);
      do_frame(5, 1'b0, 16'h0, rx);
      do_frame(16, 1'b0, 16'h0, rx);
      chk("after_abort_word", 32'(rx), 32'h1357);

      // Enqueue in the cs_fall cycle with empty buffer.
      do_frame(16, 1'b1, 16'hBEEF, rx);
      chk("enq_fall_idle", 32'(rx), 32'(IDLE));
      chk("enq_fall_level", 32'(bus.level_out), 32'd1);
      do_frame(16, 1'b0, 16'h0, rx);
      chk("enq_fall_next", 32'(rx), 32'hBEEF);
      chk("enq_fall_level_end", 32'(bus.level_out), 32'd0);

      // Randomized traffic against the model.
      for (int it = 0; it < 40; it++) begin
         int k;
         int nb;
         k = int'($urandom_range(0, 3));
         for (int j = 0; j < k; j++) enqueue(16'($urandom));
         nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : 16;
         do_frame(nb, 1'b0, 16'h0, rx);
      end

      // Asynchronous reset during bit 7 of a frame.
      while (mq.size() != 0) do_frame(16, 1'b0, 16'h0, rx);
      enqueue(16'hFFFF);
      @(posedge clk_in); #1;
      bus.chip_sel_in = 1'b0;
      repeat (6) @(posedge clk_in);
      #1;
      for (int i = 0; i < 8; i++) begin
         bus.chip_clk_in = 1'b1;
         repeat (HALF) @(posedge clk_in);
         #1;
         bus.chip_clk_in = 1'b0;
         repeat (HALF) @(posedge clk_in);
         #1;
      end
      bus.chip_clk_in = 1'b1;
      repeat (2) @(posedge clk_in);
      chk("bit7_before_rst", 32'(bus.chip_data_out), 32'd1);
      #3;
      rst_in = 1'b1;
      #1;
      chk("rst_mid_cipo", 32'(bus.chip_data_out), 32'd0);
      chk("rst_mid_level", 32'(bus.level_out), 32'd0);
      chk("rst_mid_ready", 32'(bus.sample_ready_out), 32'd1);
      chk("rst_mid_underflow", 32'(bus.underflow_out), 32'd0);
      bus.chip_clk_in = 1'b0;
      bus.chip_sel_in = 1'b1;
      mq.delete();
      m_under = 1'b0;
      repeat (3) @(posedge clk_in);
      #2;
      rst_in = 1'b0;
      repeat (4) @(posedge clk_in);
      #1;
      do_frame(16, 1'b0, 16'h0, rx);
      chk("post_rst_idle_word", 32'(rx), 32'(IDLE));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
